// File: rtl/gps_uart_tx.sv
// gps_uart_tx - 8N1 UART transmitter (LSB first) with two selectable baud rates.
//
// Sink for the GPS configuration sequencer. A byte is accepted with the
// send/busy handshake and is shifted out as start bit, 8 data bits and a stop
// bit. Each bit lasts DIV clocks, where DIV is CLK_HZ/BAUD rounded to the
// nearest integer. The divisor is captured at accept time, so a frame always
// completes at the rate it started with. A speed change is only taken in IDLE.
// When a speed mismatch and a send occur in the same IDLE cycle, the speed
// change is taken and the send is dropped.
//
// Optional feature (macro GPS_UART_TX_SWITCH_GUARD_EN):
//   When the macro is defined, every speed switch is followed by a GUARD
//   phase. GUARD holds busy=1 and tx=1 for 10 bit periods at the new rate.
//   When the macro is not defined, there is no GUARD phase and a send is
//   accepted on the cycle right after the switch.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   BAUD_LO   baud rate when speed = 0
//   BAUD_HI   baud rate when speed = 1
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   data[7:0]  in   byte to send, sampled in the accept cycle only
//   send       in   transmit request
//   busy       out  frame or guard in progress (registered)
//   req_speed  in   requested baud select (0 = LO, 1 = HI)
//   cur_speed  out  baud select in effect
//   tx         out  serial line, idle high (registered)
module gps_uart_tx #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD_LO = 9600,
  parameter int unsigned BAUD_HI = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  input  logic       req_speed,
  output logic       cur_speed,
  output logic       tx
);

  localparam int unsigned DIV_LO = (CLK_HZ + BAUD_LO / 2) / BAUD_LO;
  localparam int unsigned DIV_HI = (CLK_HZ + BAUD_HI / 2) / BAUD_HI;

  if (DIV_LO < 2 || DIV_LO > 65535) begin : g_bad_div_lo
    $error("gps_uart_tx: DIV_LO must be in 2..65535");
  end
  if (DIV_HI < 2 || DIV_HI > 65535) begin : g_bad_div_hi
    $error("gps_uart_tx: DIV_HI must be in 2..65535");
  end

  // The counter counts down from DIV-1 to 0, so a bit lasts DIV clocks.
  localparam logic [15:0] LOAD_LO = 16'(DIV_LO - 1);
  localparam logic [15:0] LOAD_HI = 16'(DIV_HI - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef GPS_UART_TX_SWITCH_GUARD_EN
    , S_GUARD
`endif
  } state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_cnt,   w_cnt_nx;
  logic [15:0] r_load,  w_load_nx;
  logic [3:0]  r_bit,   w_bit_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_speed, w_speed_nx;
  logic        r_tx,    w_tx_nx;
  logic        r_busy,  w_busy_nx;
  logic        w_cnt_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_load  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_speed <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_load  <= w_load_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_speed <= w_speed_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // The next-state logic also computes the tx and busy values for the next
  // cycle. These values are registered, so the state and the outputs change
  // on the same clock edge.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load_nx  = r_load;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_speed_nx = r_speed;
    w_tx_nx    = r_tx;
    w_busy_nx  = r_busy;
    w_cnt_zero = (r_cnt == '0);

    unique case (r_state)
      S_IDLE: begin
        w_tx_nx   = 1'b1;
        w_busy_nx = 1'b0;
        if (req_speed != r_speed) begin
          w_speed_nx = req_speed;
`ifdef GPS_UART_TX_SWITCH_GUARD_EN
          w_state_nx = S_GUARD;
          w_busy_nx  = 1'b1;
          w_load_nx  = req_speed ? LOAD_HI : LOAD_LO;
          w_cnt_nx   = w_load_nx;
          w_bit_nx   = '0;
`endif
        end else if (send) begin
          w_state_nx = S_START;
          w_shift_nx = data;
          w_tx_nx    = 1'b0;
          w_busy_nx  = 1'b1;
          w_load_nx  = r_speed ? LOAD_HI : LOAD_LO;
          w_cnt_nx   = w_load_nx;
          w_bit_nx   = '0;
        end
      end

      S_START: begin
        if (w_cnt_zero) begin
          w_state_nx = S_DATA;
          w_tx_nx    = r_shift[0];
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_cnt_nx   = r_load;
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end

      S_DATA: begin
        if (w_cnt_zero) begin
          w_cnt_nx = r_load;
          if (r_bit == 4'd7) begin
            w_state_nx = S_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit + 4'd1;
            w_tx_nx    = r_shift[0];
            w_shift_nx = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end

      S_STOP: begin
        if (w_cnt_zero) begin
          w_state_nx = S_IDLE;
          w_tx_nx    = 1'b1;
          w_busy_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end

`ifdef GPS_UART_TX_SWITCH_GUARD_EN
      // The guard lasts 10 bit periods and r_bit counts them. A single
      // 10*DIV count would not fit in the 16-bit counter.
      S_GUARD: begin
        w_tx_nx = 1'b1;
        if (w_cnt_zero) begin
          w_cnt_nx = r_load;
          if (r_bit == 4'd9) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
          end else begin
            w_bit_nx = r_bit + 4'd1;
          end
        end else begin
          w_cnt_nx = r_cnt - 16'd1;
        end
      end
`endif

      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign busy      = r_busy;
  assign tx        = r_tx;
  assign cur_speed = r_speed;

endmodule

// File: tb/tb_gps_uart_tx.sv
module tb_gps_uart_tx;

  // CLK_HZ=1000, BAUD_LO=77  -> (1000+38)/77  = 13
  // CLK_HZ=1000, BAUD_HI=300 -> (1000+150)/300 = 3
  localparam int unsigned DIV_LO_E = 13;
  localparam int unsigned DIV_HI_E = 3;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       req_speed;
  logic       cur_speed;
  logic       tx;

  int unsigned n_chk;
  int unsigned n_fail;
  logic        spd_model;

  gps_uart_tx #(
    .CLK_HZ (1000),
    .BAUD_LO(77),
    .BAUD_HI(300)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .send     (send),
    .busy     (busy),
    .req_speed(req_speed),
    .cur_speed(cur_speed),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       spd;
    logic [9:0] seq;   // seq[i] = tx level in bit period i (start..stop)
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte and checks every clock of the frame against seq.
  // hold keeps send high and puts a different byte on data during the frame.
  // toggle_at flips req_speed at that clock offset (or never if negative).
  task automatic frame(input string nm, input logic [7:0] b, input int unsigned div,
                       input logic [9:0] seq, input bit hold, input int toggle_at);
    int unsigned bad;
    logic        bad_tx;
    data = b;
    send = 1'b1;
    step();                      // accept edge E0
    if (!hold) send = 1'b0;
    else data = 8'hAA;
    for (int p = 0; p < 10; p++) begin
      bad    = 0;
      bad_tx = seq[p];
      for (int c = 0; c < int'(div); c++) begin
        if (toggle_at == p * int'(div) + c) req_speed = ~req_speed;
        if (tx !== seq[p] || busy !== 1'b1) begin
          if (bad == 0) bad_tx = tx;
          bad++;
        end
        step();
      end
      chk($sformatf("%s bit%0d bad clocks (first tx=%0b)", nm, p, bad_tx), bad, 0);
    end
    chk({nm, " end busy"}, busy, 1'b0);
    chk({nm, " end tx"}, tx, 1'b1);
  endtask

  // Checks the edge that takes the speed switch and the guard phase if it is enabled.
  task automatic expect_switch(input string nm, input logic s);
    int unsigned bad;
    step();
    chk({nm, " cur_speed"}, cur_speed, s);
    chk({nm, " tx"}, tx, 1'b1);
    spd_model = s;
`ifdef GPS_UART_TX_SWITCH_GUARD_EN
    bad = 0;
    for (int c = 0; c < int'(10 * (s ? DIV_HI_E : DIV_LO_E)); c++) begin
      if (busy !== 1'b1 || tx !== 1'b1) bad++;
      step();
    end
    chk({nm, " guard bad clocks"}, bad, 0);
    chk({nm, " guard end busy"}, busy, 1'b0);
`else
    bad = 0;
    chk({nm, " busy"}, busy, 1'b0 | bad[0]);
`endif
  endtask

  initial begin
    int unsigned bad_tx;
    int unsigned bad_busy;
    int unsigned bad_spd;

    n_chk     = 0;
    n_fail    = 0;
    spd_model = 1'b0;
    data      = 8'h00;
    send      = 1'b0;
    req_speed = 1'b0;
    rst       = 1'b1;

    vecs[0] = '{b: 8'hA5, spd: 1'b0, seq: 10'b1101001010};
    vecs[1] = '{b: 8'h81, spd: 1'b0, seq: 10'b1100000010};
    vecs[2] = '{b: 8'h55, spd: 1'b1, seq: 10'b1010101010};
    vecs[3] = '{b: 8'h3C, spd: 1'b1, seq: 10'b1001111000};
    vecs[4] = '{b: 8'hFF, spd: 1'b0, seq: 10'b1111111110};

    // Reset values
    #2 rst = 1'b0;
    repeat (3) step();
    chk("reset tx", tx, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset cur_speed", cur_speed, 1'b0);
    #4 rst = 1'b1;

    // Idle after reset: outputs hold with no activity
    bad_tx = 0; bad_busy = 0; bad_spd = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (cur_speed !== 1'b0) bad_spd++;
    end
    chk("idle tx bad clocks", bad_tx, 0);
    chk("idle busy bad clocks", bad_busy, 0);
    chk("idle cur_speed bad clocks", bad_spd, 0);

    // Table-driven frames at both rates
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].spd != spd_model) begin
        req_speed = vecs[i].spd;
        expect_switch($sformatf("vec%0d switch", i), vecs[i].spd);
      end
      frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].spd ? DIV_HI_E : DIV_LO_E,
            vecs[i].seq, 1'b0, -1);
    end

    // send held high: 0x00 then 0xFF with one idle cycle between frames.
    // The byte offered mid-frame (0xAA) must not be sent.
    frame("held0", 8'h00, DIV_LO_E, 10'b1000000000, 1'b1, -1);
    data = 8'hFF;
    frame("held1", 8'hFF, DIV_LO_E, 10'b1111111110, 1'b0, -1);

    // Speed mismatch and send in the same cycle: the switch wins
    req_speed = 1'b1;
    data      = 8'h12;
    send      = 1'b1;
    expect_switch("sw+send", 1'b1);
    send = 1'b0;
    step();
    chk("sw+send no frame busy", busy, 1'b0);
    chk("sw+send no frame tx", tx, 1'b1);
    frame("hi55", 8'h55, DIV_HI_E, 10'b1010101010, 1'b0, -1);

    // Return to LO, then request HI during a LO frame
    req_speed = 1'b0;
    expect_switch("back lo", 1'b0);
    frame("toggle", 8'hA5, DIV_LO_E, 10'b1101001010, 1'b0, 3 * DIV_LO_E + 5);
    chk("toggle cur_speed at frame end", cur_speed, 1'b0);
    expect_switch("toggle post", 1'b1);

    // Reset during data bit 3 of a HI frame
    data = 8'hA5;
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (4 * DIV_HI_E) step();
    chk("midrst pre tx", tx, 1'b0);          // A5 data bit 3 = 0
    chk("midrst pre busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst tx", tx, 1'b1);
    chk("midrst busy", busy, 1'b0);
    chk("midrst cur_speed", cur_speed, 1'b0);
    req_speed = 1'b0;
    spd_model = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("post rst busy", busy, 1'b0);
    frame("post rst 3C", 8'h3C, DIV_LO_E, 10'b1001111000, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
